// File: rtl/riscv_wb_pkg.sv
// Shared types and constants for the write-back scoreboard slice.
// The LSU tag FIFO carries a wb_tag_t per in-flight load or store.
package riscv_wb_pkg;

   localparam int unsigned TAG_ADDR_WIDTH          = 6;
   localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;

   localparam logic [TAG_ADDR_WIDTH-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic                      we;
      logic [TAG_ADDR_WIDTH-1:0] rd;
   } wb_tag_t;

endpackage

// File: rtl/riscv_wb_tag_fifo.sv
// In-order destination-tag FIFO for outstanding LSU operations.
// Depth must be a power of two so the pointers wrap by natural overflow.
module riscv_wb_tag_fifo
   import riscv_wb_pkg::*;
#(
   parameter int unsigned Depth = DEFAULT_MAX_OUTSTANDING,
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW = $clog2(Depth) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  wb_tag_t         data_i,
   input  logic            pop_i,
   output wb_tag_t         data_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);

   wb_tag_t         mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload needs no reset: it is only observed while count_q is non-zero.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/riscv_wb_scoreboard.sv
// Write-back stage: ALU pass-through on port A, in-order LSU returns on port B,
// and a per-register busy bitmap that stalls decode on hazards against loads.
module riscv_wb_scoreboard
   import riscv_wb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = TAG_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
   localparam int unsigned CntW           = $clog2(MAX_OUTSTANDING) + 1,
   localparam int unsigned NumRegs        = 2 ** ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  issue_valid_i,
   output logic                  issue_ready_o,
   input  logic                  issue_lsu_i,
   input  logic                  issue_we_i,
   input  logic [ADDR_WIDTH-1:0] issue_rd_i,
   input  logic [2:0]            issue_rs_used_i,
   input  logic [ADDR_WIDTH-1:0] issue_rs1_i,
   input  logic [ADDR_WIDTH-1:0] issue_rs2_i,
   input  logic [ADDR_WIDTH-1:0] issue_rs3_i,
   input  logic                  alu_we_i,
   input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
   input  logic [DATA_WIDTH-1:0] alu_wdata_i,
   input  logic                  lsu_rvalid_i,
   input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
   output logic [ADDR_WIDTH-1:0] waddr_a_o,
   output logic [DATA_WIDTH-1:0] wdata_a_o,
   output logic                  we_a_o,
   output logic [ADDR_WIDTH-1:0] waddr_b_o,
   output logic [DATA_WIDTH-1:0] wdata_b_o,
   output logic                  we_b_o,
   output logic [CntW-1:0]       outstanding_o,
   output logic                  err_o
);

   logic [NumRegs-1:0]    busy_q, busy_d;
   logic                  err_q, err_d;
   logic                  hazard, issue, push, rsp_pop;
   logic                  fifo_full, fifo_empty;
   wb_tag_t               push_tag, head_tag;
   logic [ADDR_WIDTH-1:0] head_rd;

   assign hazard = (issue_rs_used_i[0] && busy_q[issue_rs1_i]) ||
                   (issue_rs_used_i[1] && busy_q[issue_rs2_i]) ||
                   (issue_rs_used_i[2] && busy_q[issue_rs3_i]) ||
                   (issue_we_i && busy_q[issue_rd_i]);

   // Deliberately blind to lsu_rvalid_i: a same-cycle pop never frees a full FIFO.
   assign issue_ready_o = !hazard && !(issue_lsu_i && fifo_full);
   assign issue         = issue_valid_i && issue_ready_o;
   assign push          = issue && issue_lsu_i;
   assign rsp_pop       = lsu_rvalid_i && !fifo_empty;

   assign push_tag.we = issue_we_i && (issue_rd_i != ADDR_WIDTH'(REG_ZERO));
   assign push_tag.rd = TAG_ADDR_WIDTH'(issue_rd_i);
   assign head_rd     = ADDR_WIDTH'(head_tag.rd);

   riscv_wb_tag_fifo #(
      .Depth (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (push_tag),
      .pop_i   (rsp_pop),
      .data_o  (head_tag),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (outstanding_o)
   );

   // Set and clear never target the same register: the WAW check stalls that issue.
   always_comb begin
      busy_d = busy_q;
      if (rsp_pop && head_tag.we) busy_d[head_rd]    = 1'b0;
      if (push && push_tag.we)    busy_d[issue_rd_i] = 1'b1;
      err_d = err_q || (lsu_rvalid_i && fifo_empty);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign waddr_a_o = alu_waddr_i;
   assign wdata_a_o = alu_wdata_i;
   assign we_a_o    = alu_we_i && (alu_waddr_i != ADDR_WIDTH'(REG_ZERO));

   assign waddr_b_o = head_rd;
   assign wdata_b_o = lsu_rdata_i;
   assign we_b_o    = rsp_pop && head_tag.we;

   assign err_o = err_q;

endmodule

// File: tb/tb_riscv_wb_scoreboard.sv
// Self-checking bench: ALU vector table, directed hazard/FIFO sequences,
// then randomized traffic against a queue-based reference model.
module tb_riscv_wb_scoreboard;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int MO = 2;
   localparam int OW = $clog2(MO) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          issue_valid_i, issue_ready_o, issue_lsu_i, issue_we_i;
   logic [AW-1:0] issue_rd_i, issue_rs1_i, issue_rs2_i, issue_rs3_i;
   logic [2:0]    issue_rs_used_i;
   logic          alu_we_i;
   logic [AW-1:0] alu_waddr_i;
   logic [DW-1:0] alu_wdata_i;
   logic          lsu_rvalid_i;
   logic [DW-1:0] lsu_rdata_i;
   logic [AW-1:0] waddr_a_o, waddr_b_o;
   logic [DW-1:0] wdata_a_o, wdata_b_o;
   logic          we_a_o, we_b_o;
   logic [OW-1:0] outstanding_o;
   logic          err_o;

   int checks = 0;
   int errors = 0;

   riscv_wb_scoreboard #(
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .issue_valid_i   (issue_valid_i),
      .issue_ready_o   (issue_ready_o),
      .issue_lsu_i     (issue_lsu_i),
      .issue_we_i      (issue_we_i),
      .issue_rd_i      (issue_rd_i),
      .issue_rs_used_i (issue_rs_used_i),
      .issue_rs1_i     (issue_rs1_i),
      .issue_rs2_i     (issue_rs2_i),
      .issue_rs3_i     (issue_rs3_i),
      .alu_we_i        (alu_we_i),
      .alu_waddr_i     (alu_waddr_i),
      .alu_wdata_i     (alu_wdata_i),
      .lsu_rvalid_i    (lsu_rvalid_i),
      .lsu_rdata_i     (lsu_rdata_i),
      .waddr_a_o       (waddr_a_o),
      .wdata_a_o       (wdata_a_o),
      .we_a_o          (we_a_o),
      .waddr_b_o       (waddr_b_o),
      .wdata_b_o       (wdata_b_o),
      .we_b_o          (we_b_o),
      .outstanding_o   (outstanding_o),
      .err_o           (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      issue_valid_i   = 1'b0;
      issue_lsu_i     = 1'b0;
      issue_we_i      = 1'b0;
      issue_rd_i      = '0;
      issue_rs_used_i = '0;
      issue_rs1_i     = '0;
      issue_rs2_i     = '0;
      issue_rs3_i     = '0;
      alu_we_i        = 1'b0;
      alu_waddr_i     = '0;
      alu_wdata_i     = '0;
      lsu_rvalid_i    = 1'b0;
      lsu_rdata_i     = '0;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      #7;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic set_issue(input logic lsu, input logic we, input int rd, input logic [2:0] used,
                            input int rs1);
      issue_valid_i   = 1'b1;
      issue_lsu_i     = lsu;
      issue_we_i      = we;
      issue_rd_i      = AW'(rd);
      issue_rs_used_i = used;
      issue_rs1_i     = AW'(rs1);
      issue_rs2_i     = '0;
      issue_rs3_i     = '0;
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic          exp_we;
   } alu_vec_t;

   typedef struct {
      bit we;
      int rd;
   } mtag_t;

   alu_vec_t alu_tab[5];
   mtag_t    mq[$];
   bit       busy_m[64];
   bit       err_m;

   initial begin
      alu_tab[0] = '{we: 1'b1, waddr: 6'd0,  wdata: 32'hFFFF_0000, exp_we: 1'b0};
      alu_tab[1] = '{we: 1'b1, waddr: 6'd10, wdata: 32'h0000_1234, exp_we: 1'b1};
      alu_tab[2] = '{we: 1'b0, waddr: 6'd10, wdata: 32'hCAFE_F00D, exp_we: 1'b0};
      alu_tab[3] = '{we: 1'b1, waddr: 6'd63, wdata: 32'h8000_0001, exp_we: 1'b1};
      alu_tab[4] = '{we: 1'b1, waddr: 6'd32, wdata: 32'h0000_0000, exp_we: 1'b1};

      // Reset state
      do_reset();
      chk("rst_ready", issue_ready_o, 1);
      chk("rst_we_a", we_a_o, 0);
      chk("rst_we_b", we_b_o, 0);
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_err", err_o, 0);

      // Port A table
      for (int i = 0; i < 5; i++) begin
         alu_we_i    = alu_tab[i].we;
         alu_waddr_i = alu_tab[i].waddr;
         alu_wdata_i = alu_tab[i].wdata;
         #1;
         chk($sformatf("alu_we[%0d]", i), we_a_o, alu_tab[i].exp_we);
         chk($sformatf("alu_waddr[%0d]", i), waddr_a_o, alu_tab[i].waddr);
         chk($sformatf("alu_wdata[%0d]", i), wdata_a_o, alu_tab[i].wdata);
      end
      idle();

      // RAW against outstanding load to x5
      do_reset();
      set_issue(1, 1, 5, 3'b000, 0);
      #1 chk("ld5_ready", issue_ready_o, 1);
      tick();
      set_issue(0, 1, 6, 3'b001, 5);
      #1 chk("raw_stall0", issue_ready_o, 0);
      tick();
      #1 chk("raw_stall1", issue_ready_o, 0);
      lsu_rvalid_i = 1'b1;
      lsu_rdata_i  = 32'hDEAD_BEEF;
      #1;
      chk("raw_rsp_waddr", waddr_b_o, 5);
      chk("raw_rsp_we", we_b_o, 1);
      chk("raw_rsp_wdata", wdata_b_o, 32'hDEAD_BEEF);
      chk("raw_rsp_ready", issue_ready_o, 0);
      tick();
      lsu_rvalid_i = 1'b0;
      #1;
      chk("raw_release", issue_ready_o, 1);
      chk("raw_outstanding", outstanding_o, 0);
      tick();
      idle();

      // FIFO full: x3, x4, then x8 stalls until the cycle after a pop
      do_reset();
      set_issue(1, 1, 3, 3'b000, 0);
      tick();
      set_issue(1, 1, 4, 3'b000, 0);
      tick();
      set_issue(1, 1, 8, 3'b000, 0);
      #1;
      chk("full_ready", issue_ready_o, 0);
      chk("full_outstanding", outstanding_o, 2);
      tick();
      lsu_rvalid_i = 1'b1;
      lsu_rdata_i  = 32'h33;
      #1;
      chk("full_pop_waddr", waddr_b_o, 3);
      chk("full_pop_we", we_b_o, 1);
      chk("full_pop_ready", issue_ready_o, 0);
      tick();
      lsu_rvalid_i = 1'b0;
      #1;
      chk("full_after_ready", issue_ready_o, 1);
      chk("full_after_cnt", outstanding_o, 1);
      tick();
      issue_valid_i = 1'b0;
      #1 chk("full_refill_cnt", outstanding_o, 2);
      lsu_rvalid_i = 1'b1;
      #1 chk("full_order0", waddr_b_o, 4);
      tick();
      #1 chk("full_order1", waddr_b_o, 8);
      tick();
      lsu_rvalid_i = 1'b0;
      #1 chk("full_drained", outstanding_o, 0);
      idle();

      // Load to x0 never creates a hazard
      do_reset();
      set_issue(1, 1, 0, 3'b000, 0);
      tick();
      set_issue(0, 1, 0, 3'b111, 0);
      #1;
      chk("x0_ready", issue_ready_o, 1);
      chk("x0_cnt", outstanding_o, 1);
      idle();
      lsu_rvalid_i = 1'b1;
      #1 chk("x0_we_b", we_b_o, 0);
      tick();
      idle();

      // Store then load to x7
      do_reset();
      set_issue(1, 0, 2, 3'b000, 0);
      tick();
      set_issue(1, 1, 7, 3'b000, 0);
      tick();
      idle();
      lsu_rvalid_i = 1'b1;
      #1 chk("st_we_b", we_b_o, 0);
      tick();
      #1;
      chk("st_ld_waddr", waddr_b_o, 7);
      chk("st_ld_we", we_b_o, 1);
      tick();
      idle();

      // Empty-FIFO response and asynchronous reset mid-flight
      do_reset();
      lsu_rvalid_i = 1'b1;
      #1 chk("err_we_b", we_b_o, 0);
      tick();
      lsu_rvalid_i = 1'b0;
      #1 chk("err_set", err_o, 1);
      tick();
      #1 chk("err_sticky", err_o, 1);
      set_issue(1, 1, 9, 3'b000, 0);
      tick();
      set_issue(0, 0, 1, 3'b001, 9);
      #1;
      chk("x9_busy", issue_ready_o, 0);
      chk("x9_cnt", outstanding_o, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_ready", issue_ready_o, 1);
      chk("arst_cnt", outstanding_o, 0);
      chk("arst_err", err_o, 0);
      rst_n = 1'b1;
      idle();
      tick();
      lsu_rvalid_i = 1'b1;
      tick();
      lsu_rvalid_i = 1'b0;
      #1 chk("late_rsp_err", err_o, 1);

      // Concurrent port A and port B writes
      do_reset();
      set_issue(1, 1, 11, 3'b000, 0);
      tick();
      idle();
      alu_we_i     = 1'b1;
      alu_waddr_i  = 6'd10;
      alu_wdata_i  = 32'h1234;
      lsu_rvalid_i = 1'b1;
      lsu_rdata_i  = 32'h55AA_66BB;
      #1;
      chk("dual_we_a", we_a_o, 1);
      chk("dual_waddr_a", waddr_a_o, 10);
      chk("dual_wdata_a", wdata_a_o, 32'h1234);
      chk("dual_we_b", we_b_o, 1);
      chk("dual_waddr_b", waddr_b_o, 11);
      chk("dual_wdata_b", wdata_b_o, 32'h55AA_66BB);
      tick();
      idle();

      // Randomized traffic against the reference model
      do_reset();
      mq.delete();
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      err_m = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit    exp_ready, exp_we_b, hz;
         mtag_t t;
         issue_valid_i   = ($urandom_range(0, 3) != 0);
         issue_lsu_i     = $urandom_range(0, 1);
         issue_we_i      = $urandom_range(0, 1);
         issue_rd_i      = AW'($urandom_range(0, 7));
         issue_rs_used_i = 3'($urandom);
         issue_rs1_i     = AW'($urandom_range(0, 7));
         issue_rs2_i     = AW'($urandom_range(0, 7));
         issue_rs3_i     = AW'($urandom_range(0, 7));
         alu_we_i        = $urandom_range(0, 1);
         alu_waddr_i     = AW'($urandom_range(0, 3));
         alu_wdata_i     = $urandom;
         // Responses only while loads are in flight, except for a rare stray pulse
         lsu_rvalid_i    = (mq.size() > 0) ? ($urandom_range(0, 2) == 0)
                                           : (cyc > 2500 && $urandom_range(0, 50) == 0);
         lsu_rdata_i     = $urandom;
         #1;
         hz = (issue_rs_used_i[0] && busy_m[issue_rs1_i]) ||
              (issue_rs_used_i[1] && busy_m[issue_rs2_i]) ||
              (issue_rs_used_i[2] && busy_m[issue_rs3_i]) ||
              (issue_we_i && busy_m[issue_rd_i]);
         exp_ready = !hz && !(issue_lsu_i && mq.size() == MO);
         exp_we_b  = lsu_rvalid_i && mq.size() > 0 && mq[0].we;
         chk("rnd_ready", issue_ready_o, exp_ready);
         chk("rnd_we_b", we_b_o, exp_we_b);
         if (exp_we_b) begin
            chk("rnd_waddr_b", waddr_b_o, mq[0].rd);
            chk("rnd_wdata_b", wdata_b_o, lsu_rdata_i);
         end
         chk("rnd_we_a", we_a_o, alu_we_i && alu_waddr_i != 0);
         chk("rnd_outstanding", outstanding_o, mq.size());
         chk("rnd_err", err_o, err_m);
         if (lsu_rvalid_i) begin
            if (mq.size() > 0) begin
               t = mq.pop_front();
               if (t.we) busy_m[t.rd] = 1'b0;
            end else begin
               err_m = 1'b1;
            end
         end
         if (issue_valid_i && exp_ready && issue_lsu_i) begin
            t.we = issue_we_i && issue_rd_i != 0;
            t.rd = int'(issue_rd_i);
            mq.push_back(t);
            if (t.we) busy_m[t.rd] = 1'b1;
         end
         tick();
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_wb_scoreboard.md
Name: riscv_wb_scoreboard

Overview:
Write-back and hazard stage that sits directly upstream of the register file and drives both of its write ports. Port A carries single-cycle ALU results straight through. Port B carries in-order LSU load returns, tagged from an internal destination FIFO. A per-register busy bitmap stalls decode on RAW/WAW hazards against outstanding loads.

Parameters:
ADDR_WIDTH, 6, register address width; MSB selects the FP bank when the FPU is present.
DATA_WIDTH, 32, register data width.
MAX_OUTSTANDING, 2, maximum in-flight LSU ops; tag FIFO depth; power of 2, at least 2.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
issue_valid_i  in  1  decode presents an instruction
issue_ready_o  out  1  instruction accepted this cycle
issue_lsu_i  in  1  instruction is an LSU op (load or store)
issue_we_i  in  1  instruction writes rd
issue_rd_i  in  ADDR_WIDTH  destination register
issue_rs_used_i  in  3  use flags for rs1/rs2/rs3
issue_rs1_i / issue_rs2_i / issue_rs3_i  in  ADDR_WIDTH each  source registers
alu_we_i  in  1  ALU result valid
alu_waddr_i  in  ADDR_WIDTH  ALU destination
alu_wdata_i  in  DATA_WIDTH  ALU result
lsu_rvalid_i  in  1  LSU response pulse, in order, no backpressure
lsu_rdata_i  in  DATA_WIDTH  load data
waddr_a_o / wdata_a_o / we_a_o  out  ADDR_WIDTH / DATA_WIDTH / 1  register file write port A
waddr_b_o / wdata_b_o / we_b_o  out  ADDR_WIDTH / DATA_WIDTH / 1  register file write port B
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  in-flight LSU op count
err_o  out  1  sticky: response arrived with the FIFO empty

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: busy bitmap 0, FIFO empty, outstanding_o 0, err_o 0, issue_ready_o 1, we_a_o 0, we_b_o 0.
- Busy bitmap: 2**ADDR_WIDTH flops. Register 0 is never marked busy.
- Hazard: any used rsN with busy[rsN]=1 (RAW), or issue_we_i with busy[issue_rd_i]=1 (WAW).
- issue_ready_o = !hazard && !(issue_lsu_i && fifo_full).
  - Combinational from issue inputs and state only.
  - Does not depend on lsu_rvalid_i, so a same-cycle pop does not unblock a full FIFO.
- Issue = issue_valid_i && issue_ready_o.
  - If issue_lsu_i: push {we = issue_we_i && rd != 0, rd} into the FIFO.
  - If the pushed entry has we=1: set busy[rd] at the clock edge.
  - Non-LSU issues change no state.
- Response (lsu_rvalid_i=1, FIFO non-empty): pop the head in the same cycle.
  - waddr_b_o = head.rd, wdata_b_o = lsu_rdata_i, we_b_o = head.we. Path is combinational, zero latency.
  - busy[head.rd] clears at the same edge the register file writes.
  - An instruction reading rd issues the following cycle and sees the new data.
- Response with the FIFO empty: we_b_o=0, no state change, err_o set. err_o holds until reset.
- Port A is combinational pass-through of the alu_* signals.
  - we_a_o = alu_we_i && alu_waddr_i != 0.
  - Port A never touches the busy bitmap.
- Simultaneous push and pop: both take effect. outstanding_o is unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- Busy set and clear on the same register in one cycle cannot occur: the WAW check stalls the issue. No priority rule is needed.
- Same-address writes on ports A and B in one cycle are excluded by the WAW check. The register file gives port B priority regardless.
- Reset mid-operation clears all state. Late LSU responses after reset set err_o.

Decomposition:
- Package riscv_wb_pkg:
  - wb_tag_t typedef (struct of we plus rd).
  - REG_ZERO constant.
  - Default MAX_OUTSTANDING constant.
- One sub-module, riscv_wb_tag_fifo: parameterised sync FIFO of wb_tag_t with push/pop/full/empty/count, asynchronous active-low reset.
- The scoreboard bitmap and hazard logic stay in the top module.

Test Plan:
- Load x5, then ADD rs1=x5 on the next cycle: issue_ready_o=0 until lsu_rvalid_i with rdata=0xDEADBEEF; that cycle drives waddr_b_o=5, we_b_o=1; the ADD issues on the next cycle.
- Two loads to x3 and x4 (depth 2), then a third load: third stalls with outstanding_o=2; the response pops x3 first; the third load still stalls that cycle and issues the cycle after.
- Load with rd=x0: no busy bit is set; the response gives we_b_o=0; an instruction reading x0 never stalls.
- Store (lsu=1, we=0) followed by a load to x7: the first response gives we_b_o=0, the second gives waddr_b_o=7; FIFO ordering is preserved.
- lsu_rvalid_i with the FIFO empty: err_o=1 and stays 1; pull rst_n low mid-flight with x9 busy: busy, outstanding_o and err_o all read 0 immediately.
- alu_we_i=1, waddr=10, wdata=0x1234 concurrent with a load return to x11: we_a_o=1 and we_b_o=1 in the same cycle with the correct data on each port.
